hazard_scoreboard: RTL and testbench

//  Per-register scoreboard replacing fixed EX/MEM hazard comparators in ID. Every issued writer records
//  a latency countdown for its destination; ID checks NUM_SRC source operands against it and raises a

---
 rtl/hazard_scoreboard_pkg.sv | 17 +
 rtl/sb_entry.sv | 52 +++++
 rtl/hazard_scoreboard.sv | 78 +++++++
 tb/tb_hazard_scoreboard.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared widths and latency codes for the ID-stage hazard scoreboard and the decoder driving it.
package hazard_scoreboard_pkg;

    localparam int unsigned NUM_REGS_DEF = 32;
    localparam int unsigned REG_AW_DEF   = 5;
    localparam int unsigned LAT_W_DEF    = 3;
    localparam int unsigned NUM_SRC_DEF  = 2;
    localparam int unsigned STAT_W_DEF   = 32;

    // Issue latencies: cycles until the result can be forwarded to the EX input.
    localparam logic [LAT_W_DEF-1:0] LAT_ALU  = LAT_W_DEF'(1);
    localparam logic [LAT_W_DEF-1:0] LAT_LOAD = LAT_W_DEF'(2);
    localparam logic [LAT_W_DEF-1:0] LAT_MFC0 = LAT_W_DEF'(2);
    // All-ones marks a variable-latency writer that completes on wb_done.
    localparam logic [LAT_W_DEF-1:0] LAT_VAR  = {LAT_W_DEF{1'b1}};

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: tracks an outstanding writer for a single register.
module sb_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned LAT_W = LAT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic [LAT_W-1:0] lat,
    input  logic             hold,
    input  logic             clr_var,
    input  logic             flush,
    output logic             busy_norm,
    output logic             busy_branch
);

    localparam logic [LAT_W-1:0] VAR_CODE = {LAT_W{1'b1}};

    logic             valid;
    logic [LAT_W-1:0] rem;

    // Entry state: set wins over completion, fixed latencies count down unless the back end holds.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid <= 1'b0;
            rem   <= '0;
        end else if (set) begin
            // A zero-latency writer is ready at once, so it simply retires any older writer.
            valid <= (lat != '0);
            rem   <= lat;
        end else if (valid) begin
            if (rem == VAR_CODE) begin
                if (clr_var) begin
                    valid <= 1'b0;
                    rem   <= '0;
                end
            end else if (!hold) begin
                if (rem != '0) begin
                    rem <= rem - LAT_W'(1);
                end else begin
                    valid <= 1'b0;
                end
            end
        end
    end

    // The variable code is all-ones, so it is always above both thresholds.
    assign busy_norm   = valid && (rem > LAT_W'(1));
    assign busy_branch = valid && (rem != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard in ID: produces the IF/ID stall and counts stalled cycles.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned REG_AW   = REG_AW_DEF,
    parameter int unsigned LAT_W    = LAT_W_DEF,
    parameter int unsigned NUM_SRC  = NUM_SRC_DEF,
    parameter int unsigned STAT_W   = STAT_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      issue_valid,
    input  logic [REG_AW-1:0]         issue_rd,
    input  logic [LAT_W-1:0]          issue_lat,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr,
    input  logic                      is_branch,
    input  logic                      back_hold,
    input  logic                      wb_done,
    input  logic [REG_AW-1:0]         wb_rd,
    input  logic                      flush,
    output logic                      stall,
    output logic [STAT_W-1:0]         stall_cycles
);

    logic [NUM_REGS-1:0] busy_norm;
    logic [NUM_REGS-1:0] busy_branch;
    logic [NUM_SRC-1:0]  not_ready;

    // Register 0 is hard-wired and never has an outstanding writer.
    assign busy_norm[0]   = 1'b0;
    assign busy_branch[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        logic set;
        logic clr_var;

        assign set     = issue_valid && !stall && !flush && (issue_rd == REG_AW'(r));
        assign clr_var = wb_done && (wb_rd == REG_AW'(r));

        sb_entry #(
            .LAT_W (LAT_W)
        ) u_entry (
            .clk         (clk),
            .reset       (reset),
            .set         (set),
            .lat         (issue_lat),
            .hold        (back_hold),
            .clr_var     (clr_var),
            .flush       (flush),
            .busy_norm   (busy_norm[r]),
            .busy_branch (busy_branch[r])
        );
    end

    // Branches resolve in ID and need their operands one cycle earlier than EX consumers.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_AW-1:0] addr;

        assign addr         = src_addr[i*REG_AW +: REG_AW];
        assign not_ready[i] = src_valid[i] && (addr != '0) &&
                              (is_branch ? busy_branch[addr] : busy_norm[addr]);
    end

    assign stall = en && !flush && (|not_ready);

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != {STAT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a narrow stall counter to reach saturation.
`timescale 1ns/1ps
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int unsigned AW = 5;
    localparam int unsigned LW = 3;
    localparam int unsigned NS = 2;
    localparam int unsigned SW = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             issue_valid;
    logic [AW-1:0]    issue_rd;
    logic [LW-1:0]    issue_lat;
    logic [NS-1:0]    src_valid;
    logic [NS*AW-1:0] src_addr;
    logic             is_branch;
    logic             back_hold;
    logic             wb_done;
    logic [AW-1:0]    wb_rd;
    logic             flush;
    logic             stall;
    logic [SW-1:0]    stall_cycles;

    int total = 0;
    int bad   = 0;

    hazard_scoreboard #(
        .NUM_REGS (32),
        .REG_AW   (AW),
        .LAT_W    (LW),
        .NUM_SRC  (NS),
        .STAT_W   (SW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_lat    (issue_lat),
        .src_valid    (src_valid),
        .src_addr     (src_addr),
        .is_branch    (is_branch),
        .back_hold    (back_hold),
        .wb_done      (wb_done),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .stall        (stall),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset       = 1'b0;
        en          = 1'b1;
        issue_valid = 1'b0;
        issue_rd    = '0;
        issue_lat   = '0;
        src_valid   = '0;
        src_addr    = '0;
        is_branch   = 1'b0;
        back_hold   = 1'b0;
        wb_done     = 1'b0;
        wb_rd       = '0;
        flush       = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        next();
        reset = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] rd, input logic [LW-1:0] lat);
        issue_valid = 1'b1;
        issue_rd    = rd;
        issue_lat   = lat;
    endtask

    task automatic set_src(input int i, input logic v, input logic [AW-1:0] a);
        src_valid[i]         = v;
        src_addr[i*AW +: AW] = a;
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        #1;
        total++;
        assert (stall === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, stall, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [SW-1:0] exp);
        total++;
        assert (stall_cycles === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, stall_cycles, exp);
        end
    endtask

    initial begin
        // Reset held two cycles while an issue is presented.
        idle();
        reset = 1'b1;
        issue(5'd8, LAT_LOAD);
        next();
        next();
        idle();
        chk_cnt("reset_cnt", 4'd0);
        is_branch = 1'b1;
        for (int r = 1; r < 32; r++) begin
            set_src(0, 1'b1, AW'(r));
            chk_stall($sformatf("reset_empty_r%0d", r), 1'b0);
        end

        // Load r8 then a normal consumer: one stall cycle.
        do_reset();
        issue(5'd8, LAT_LOAD);
        next();
        idle();
        set_src(0, 1'b1, 5'd8);
        chk_stall("load_norm_t1", 1'b1);
        next();
        chk_stall("load_norm_t2", 1'b0);
        chk_cnt("load_norm_cnt", 4'd1);

        // Load r8 then a branch on operand 1: two stall cycles.
        do_reset();
        issue(5'd8, LAT_LOAD);
        next();
        idle();
        is_branch = 1'b1;
        set_src(1, 1'b1, 5'd8);
        chk_stall("load_br_t1", 1'b1);
        next();
        chk_stall("load_br_t2", 1'b1);
        next();
        chk_stall("load_br_t3", 1'b0);
        chk_cnt("load_br_cnt", 4'd2);

        // ALU producer: normal consumer free, branch stalls.
        do_reset();
        issue(5'd5, LAT_ALU);
        next();
        idle();
        set_src(0, 1'b1, 5'd5);
        chk_stall("alu_norm", 1'b0);
        is_branch = 1'b1;
        chk_stall("alu_br_t1", 1'b1);
        next();
        chk_stall("alu_br_t2", 1'b0);

        // Divider r9: stall held until wb_done, counter saturates at 15.
        do_reset();
        issue(5'd9, LAT_VAR);
        next();
        idle();
        set_src(0, 1'b1, 5'd9);
        for (int i = 0; i < 20; i++) begin
            if (i == 10) chk_cnt("div_cnt_10", 4'd10);
            chk_stall($sformatf("div_hold_%0d", i), 1'b1);
            next();
        end
        wb_done = 1'b1;
        wb_rd   = 5'd9;
        chk_stall("div_wb_cycle", 1'b1);
        next();
        wb_done = 1'b0;
        chk_stall("div_after_wb", 1'b0);
        chk_cnt("div_cnt_sat", 4'd15);

        // Same-cycle reissue to r9 beats wb_done.
        do_reset();
        issue(5'd9, LAT_VAR);
        next();
        issue(5'd9, LAT_ALU);
        wb_done = 1'b1;
        wb_rd   = 5'd9;
        next();
        idle();
        set_src(0, 1'b1, 5'd9);
        chk_stall("reissue_norm", 1'b0);
        is_branch = 1'b1;
        chk_stall("reissue_br", 1'b1);

        // wb_done on a fixed-latency entry leaves it alone.
        do_reset();
        issue(5'd10, LAT_LOAD);
        next();
        idle();
        is_branch = 1'b1;
        set_src(0, 1'b1, 5'd10);
        wb_done = 1'b1;
        wb_rd   = 5'd10;
        chk_stall("wb_fixed_t1", 1'b1);
        next();
        wb_done = 1'b0;
        chk_stall("wb_fixed_t2", 1'b1);

        // back_hold freezes the countdown.
        do_reset();
        issue(5'd8, LAT_LOAD);
        next();
        idle();
        set_src(0, 1'b1, 5'd8);
        back_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk_stall($sformatf("hold_%0d", i), 1'b1);
            next();
        end
        back_hold = 1'b0;
        chk_stall("hold_drop", 1'b1);
        next();
        chk_stall("hold_release", 1'b0);

        // r0, src_valid, en masking; issue ignored while stalled.
        do_reset();
        issue(5'd8, LAT_VAR);
        next();
        issue(5'd0, LAT_VAR);
        next();
        idle();
        set_src(0, 1'b1, 5'd0);
        chk_stall("r0_ignored", 1'b0);
        set_src(0, 1'b0, 5'd8);
        chk_stall("src_invalid", 1'b0);
        set_src(0, 1'b1, 5'd8);
        en = 1'b0;
        chk_stall("en_low", 1'b0);
        en = 1'b1;
        chk_stall("en_high", 1'b1);
        issue(5'd8, LAT_ALU);
        next();
        idle();
        set_src(0, 1'b1, 5'd8);
        chk_stall("stalled_issue_dropped", 1'b1);

        // Flush with r8, r11, r12 pending; issue to r13 in the flush cycle dropped.
        idle();
        issue(5'd11, LAT_LOAD);
        next();
        issue(5'd12, 3'd3);
        next();
        idle();
        issue(5'd13, LAT_LOAD);
        flush = 1'b1;
        set_src(0, 1'b1, 5'd8);
        set_src(1, 1'b1, 5'd11);
        chk_stall("flush_cycle", 1'b0);
        next();
        idle();
        set_src(0, 1'b1, 5'd8);
        set_src(1, 1'b1, 5'd11);
        chk_stall("flush_after_norm", 1'b0);
        is_branch = 1'b1;
        set_src(0, 1'b1, 5'd12);
        set_src(1, 1'b1, 5'd13);
        chk_stall("flush_after_br", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
